// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared definitions for the RV32 load/store unit.
//   - funct3 access-width encodings (B, H, W, BU, HU)
//   - fault codes reported on fault_out
//   - FSM state enum (IDLE, REQ, DONE)
//   - helpers that classify a request as illegal or misaligned
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so funct3[2] is illegal for them.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

  // size_code is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] size_code, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (size_code)
      2'b01:   m = addr_lo[0];
      2'b10:   m = (addr_lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3_i     [2:0]  access width/sign
//   addr_lo_i    [1:0]  byte offset within the word
//   store_data_i [31:0] rs2 value
//   rdata_i      [31:0] word read from memory
//   be_o         [3:0]  byte enables
//   wdata_o      [31:0] store data replicated across lanes
//   load_data_o  [31:0] selected lane, sign/zero extended
module lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  // Move the addressed lane down to bit 0 before extracting.
  logic [31:0] lane_word;
  assign lane_word = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{lane_word[7]}}, lane_word[7:0]};
      F3_BU:   load_data_o = {24'h0, lane_word[7:0]};
      F3_H:    load_data_o = {{16{lane_word[15]}}, lane_word[15:0]};
      F3_HU:   load_data_o = {16'h0, lane_word[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store engine between EX and a
// simple ready-handshake data memory.
// Handshake: start_in is a one-cycle request accepted only in IDLE. The memory
// request (dmem_req_out plus addr/we/be/wdata) is held stable until a cycle in
// which dmem_ready_in=1; that cycle is the accept and rdata is valid in it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_in, is_store_in, funct3_in, addr_in, store_data_in, rd_in   request
//   dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
//   dmem_ready_in, dmem_rdata_in                                       memory
//   busy_out, done_out, rd_we_out, rd_out, load_data_out, fault_out    result
//   state_dbg_out            current FSM state
module load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        is_store_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_ready_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        rd_we_out,
  output logic [4:0]  rd_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  fault_out,
  output logic [1:0]  state_dbg_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last REQ cycle allowed before timing out.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           store_q, store_d;
  logic [2:0]     f3_q, f3_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    sdata_q, sdata_d;
  logic [4:0]     rd_req_q, rd_req_d;
  // Result registers only change on entry to DONE so they hold otherwise.
  logic [4:0]     rd_out_q, rd_out_d;
  logic [1:0]     fault_q, fault_d;
  logic [31:0]    load_q, load_d;

  logic [3:0]     al_be;
  logic [31:0]    al_wdata;
  logic [31:0]    al_load;

  lsu_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata_in),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    rd_req_d = rd_req_q;
    rd_out_d = rd_out_q;
    fault_d  = fault_q;
    load_d   = load_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          store_d  = is_store_in;
          f3_d     = funct3_in;
          addr_d   = addr_in;
          sdata_d  = store_data_in;
          rd_req_d = rd_in;
          cnt_d    = '0;
          if (f3_illegal(funct3_in, is_store_in)) begin
            state_d  = ST_DONE;
            fault_d  = FAULT_ILLEGAL;
            rd_out_d = rd_in;
          end else if (misaligned(funct3_in[1:0], addr_in[1:0])) begin
            state_d  = ST_DONE;
            fault_d  = FAULT_MISALIGN;
            rd_out_d = rd_in;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ready wins over timeout in the final allowed cycle.
        if (dmem_ready_in) begin
          state_d  = ST_DONE;
          fault_d  = FAULT_NONE;
          rd_out_d = rd_req_q;
          if (!store_q) load_d = al_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          fault_d  = FAULT_TIMEOUT;
          rd_out_d = rd_req_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      sdata_q  <= '0;
      rd_req_q <= '0;
      rd_out_q <= '0;
      fault_q  <= FAULT_NONE;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      rd_req_q <= rd_req_d;
      rd_out_q <= rd_out_d;
      fault_q  <= fault_d;
      load_q   <= load_d;
    end
  end

  // Memory-side outputs are driven only while a request is outstanding.
  assign dmem_req_out   = (state_q == ST_REQ);
  assign dmem_we_out    = dmem_req_out && store_q;
  assign dmem_addr_out  = dmem_req_out ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_out    = dmem_req_out ? al_be : 4'b0000;
  assign dmem_wdata_out = dmem_req_out ? al_wdata : 32'h0;

  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = (state_q == ST_DONE);
  assign rd_we_out     = done_out && !store_q && (fault_q == FAULT_NONE) && (rd_out_q != 5'd0);
  assign rd_out        = rd_out_q;
  assign fault_out     = fault_q;
  assign load_data_out = load_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against an access-level reference model (sizes, lane offsets, latencies).
module tb_load_store_unit;
  import rv32_lsu_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in, is_store_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic [4:0]  rd_in;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ready_in;
  logic [31:0] dmem_rdata_in;
  logic        busy_out, done_out, rd_we_out;
  logic [4:0]  rd_out;
  logic [31:0] load_data_out;
  logic [1:0]  fault_out;
  logic [1:0]  state_dbg_out;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] last_fault;
  logic [4:0] last_rd;

  load_store_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .is_store_in(is_store_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .rd_in(rd_in), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_be_out(dmem_be_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_ready_in(dmem_ready_in),
    .dmem_rdata_in(dmem_rdata_in), .busy_out(busy_out), .done_out(done_out),
    .rd_we_out(rd_we_out), .rd_out(rd_out), .load_data_out(load_data_out),
    .fault_out(fault_out), .state_dbg_out(state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int size = access_size(f3);
    int ofs = int'(addr[1:0]);
    logic [31:0] v, mask;
    if (size == 4) return rdata;
    v = rdata >> (8 * ofs);
    mask = (32'd1 << (8 * size)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  // One access from the idle cycle through its DONE cycle. junk=1 also
  // raises start_in during DONE, which must be ignored.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd, input int wait_c,
                           input logic [31:0] rdata, input logic junk, input string tag);
    int size, ofs, done_rel;
    logic illegal, mis, e_req, e_rd_we;
    logic [1:0] e_fault;
    logic [3:0] e_be;
    logic [31:0] e_wdata, e_load;
    size = access_size(f3);
    ofs = int'(addr[1:0]);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
    mis = (ofs % size) != 0;
    e_fault = illegal ? 2'b10 : (mis ? 2'b01 : ((wait_c >= TB_TIMEOUT) ? 2'b11 : 2'b00));
    done_rel = (illegal || mis) ? 1 : ((wait_c >= TB_TIMEOUT) ? 1 + TB_TIMEOUT : 2 + wait_c);
    e_be = 4'(((1 << size) - 1) << ofs);
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
    e_load = model_load(f3, addr, rdata);
    e_rd_we = !st && (e_fault == 2'b00) && (rd != 5'd0);

    tick();
    n_vec++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || state_dbg_out !== 2'd0) begin
      n_err++;
      $display("FAIL %s idle: busy=%b done=%b state=%0d, want 0 0 0", tag, busy_out, done_out, state_dbg_out);
    end
    start_in = 1'b1; is_store_in = st; funct3_in = f3; addr_in = addr;
    store_data_in = sdata; rd_in = rd; dmem_ready_in = 1'b0;

    for (int c = 1; c <= done_rel; c++) begin
      tick();
      start_in = (c == done_rel) ? junk : 1'($urandom_range(0, 1));
      is_store_in = 1'($urandom); funct3_in = 3'($urandom);
      addr_in = $urandom; store_data_in = $urandom; rd_in = 5'($urandom);
      e_req = (e_fault == 2'b00 || e_fault == 2'b11) && (c < done_rel);
      n_vec++;
      if (dmem_req_out !== e_req || busy_out !== 1'b1 || done_out !== (c == done_rel)) begin
        n_err++;
        $display("FAIL %s ctl c%0d: req=%b busy=%b done=%b, want %b 1 %b", tag, c,
                 dmem_req_out, busy_out, done_out, e_req, (c == done_rel));
      end
      if (e_req) begin
        n_vec++;
        if ({dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out} !==
            {st, addr[31:2], 2'b00, e_be, e_wdata}) begin
          n_err++;
          $display("FAIL %s bus c%0d: we=%b addr=%h be=%b wdata=%h, want %b %h %b %h", tag, c,
                   dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
                   st, {addr[31:2], 2'b00}, e_be, e_wdata);
        end
      end
      if (c == done_rel) begin
        n_vec++;
        if (fault_out !== e_fault || rd_out !== rd || rd_we_out !== e_rd_we) begin
          n_err++;
          $display("FAIL %s result: fault=%b rd=%0d rd_we=%b, want %b %0d %b", tag,
                   fault_out, rd_out, rd_we_out, e_fault, rd, e_rd_we);
        end
        if (!st && e_fault == 2'b00) begin
          n_vec++;
          if (load_data_out !== e_load) begin
            n_err++;
            $display("FAIL %s load_data: got %h, want %h", tag, load_data_out, e_load);
          end
        end
      end else begin
        n_vec++;
        if (rd_we_out !== 1'b0 || fault_out !== last_fault || rd_out !== last_rd) begin
          n_err++;
          $display("FAIL %s hold c%0d: rd_we=%b fault=%b rd=%0d, want 0 %b %0d", tag, c,
                   rd_we_out, fault_out, rd_out, last_fault, last_rd);
        end
      end
      dmem_ready_in = e_req && (c == 1 + wait_c);
      dmem_rdata_in = dmem_ready_in ? rdata : $urandom;
    end
    last_fault = e_fault;
    last_rd = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; is_store_in = 1'b0; funct3_in = 3'b000;
    addr_in = '0; store_data_in = '0; rd_in = '0; dmem_ready_in = 1'b0; dmem_rdata_in = '0;
    tick();
    tick();
    n_vec++;
    if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out, busy_out,
         done_out, rd_we_out, rd_out, load_data_out, fault_out, state_dbg_out} !== '0) begin
      n_err++;
      $display("FAIL reset: req=%b busy=%b done=%b rd=%0d load=%h fault=%b, want all 0",
               dmem_req_out, busy_out, done_out, rd_out, load_data_out, fault_out);
    end
    rst = 1'b0;
    last_fault = 2'b00;
    last_rd = 5'd0;
  endtask

  task automatic test_lw();
    do_access(1'b0, F3_W, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF, 1'b0, "lw");
  endtask

  task automatic test_lb_lbu();
    do_access(1'b0, F3_B,  32'h203, 32'h0, 5'd6, 0, 32'h80123456, 1'b0, "lb");
    do_access(1'b0, F3_BU, 32'h203, 32'h0, 5'd6, 1, 32'h80123456, 1'b0, "lbu");
    do_access(1'b0, F3_H,  32'h202, 32'h0, 5'd8, 0, 32'h9ABC0000, 1'b0, "lh");
    do_access(1'b0, F3_HU, 32'h202, 32'h0, 5'd8, 2, 32'h9ABC0000, 1'b0, "lhu");
  endtask

  task automatic test_sh();
    do_access(1'b1, F3_H, 32'h302, 32'h1234ABCD, 5'd7, 0, 32'h0, 1'b0, "sh");
    do_access(1'b1, F3_B, 32'h301, 32'h000000A5, 5'd7, 1, 32'h0, 1'b0, "sb");
  endtask

  task automatic test_faults();
    do_access(1'b0, F3_W,   32'h101, 32'h0, 5'd3, 0, 32'h0, 1'b0, "mis_lw");
    do_access(1'b0, F3_HU,  32'h105, 32'h0, 5'd3, 0, 32'h0, 1'b0, "mis_lhu");
    do_access(1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 0, 32'h0, 1'b0, "ill_ld");
    do_access(1'b1, F3_BU,  32'h100, 32'h0, 5'd4, 0, 32'h0, 1'b0, "ill_st");
  endtask

  task automatic test_timeout();
    do_access(1'b0, F3_W, 32'h440, 32'h0, 5'd9, 100, 32'h0, 1'b1, "timeout");
    do_access(1'b0, F3_W, 32'h444, 32'h0, 5'd9, TB_TIMEOUT - 1, 32'h0BADF00D, 1'b0, "last_cyc");
  endtask

  task automatic test_reset_mid_req();
    tick();
    start_in = 1'b1; is_store_in = 1'b0; funct3_in = F3_W; addr_in = 32'h400; rd_in = 5'd9;
    dmem_ready_in = 1'b0;
    tick();
    start_in = 1'b0;
    n_vec++;
    if (dmem_req_out !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid pre: req=%b, want 1", dmem_req_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({dmem_req_out, busy_out, done_out, rd_out, fault_out, load_data_out} !== '0) begin
      n_err++;
      $display("FAIL rst_mid abort: req=%b busy=%b done=%b rd=%0d fault=%b load=%h, want all 0",
               dmem_req_out, busy_out, done_out, rd_out, fault_out, load_data_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (done_out !== 1'b0 || busy_out !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid idle%0d: done=%b busy=%b, want 0 0", i, done_out, busy_out);
      end
    end
    last_fault = 2'b00;
    last_rd = 5'd0;
    do_access(1'b0, F3_W, 32'h404, 32'h0, 5'd10, 0, 32'h13572468, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_access(1'($urandom), F3_W, {$urandom_range(0, 255), 2'b00}, $urandom, 5'($urandom),
                $urandom_range(0, 1), $urandom, 1'b1, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++)
      do_access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 5), $urandom, 1'($urandom), "rand");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_faults();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    start_in = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
